latch_load_ctrl: RTL



---
 rtl/latch_load_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/latch_load_ctrl.sv
// Loader for a transparent latch: captures one word per handshake, then runs
// a setup -> enable pulse -> hold sequence so the latch input is stable while enabled.
module latch_load_ctrl #(
    parameter int n         = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [n-1:0] d_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic [n-1:0] d_out,
    output logic         en_out,
    output logic         done_out,
    output logic         busy_out
);

    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXP   = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW     = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] C_PULSE = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [n-1:0]   r_d;
    logic           r_en;
    logic           r_done;
    logic           w_accept;

    // Ready is masked by reset so a word offered on a reset edge is visibly refused.
    assign ready_out = (r_state == S_IDLE) && !rst_in;
    assign busy_out  = (r_state != S_IDLE);
    assign w_accept  = valid_in && ready_out;

    assign d_out    = r_d;
    assign en_out   = r_en;
    assign done_out = r_done;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_d     <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_d     <= d_in;
                        r_cnt   <= C_SETUP;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b1;
                        r_cnt   <= C_PULSE;
                        r_state <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b0;
                        r_cnt   <= C_HOLD;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                S_HOLD: begin
                    // done rises together with the return to IDLE, so it lines up with ready.
                    if (r_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
            endcase
        end
    end

endmodule
